// File: rtl/digit_entry_pkg.sv
// Shared display-path constants for the digit entry block and the display mux consumers.
package digit_entry_pkg;

   typedef enum logic [1:0] {
      INPUT_STATE_IDLE = 2'd0,
      INPUT_STATE_ONES = 2'd1,
      INPUT_STATE_TENS = 2'd2,
      INPUT_STATE_HUNS = 2'd3
   } input_state_e;

   localparam logic [4:0] BCD_BLANK = 5'd16;
   localparam logic [4:0] BCD_MINUS = 5'd17;

   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [3:0] bcd_dec(input logic [3:0] d);
      return (d == 4'd0) ? 4'd9 : d - 4'd1;
   endfunction

endpackage

// File: rtl/digit_entry_btn_cond.sv
// Raw button conditioning: 2-flop synchronizer, optional debounce, registered rising-edge pulse.
// Debounce is built only when DIGIT_ENTRY_DEBOUNCE_EN is defined.
module btn_cond #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic evt
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;
   logic evt_q, evt_d;
   logic level;

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;

   // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         db_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end

   assign level = db_q;
`else
   assign level = sync2_q;
`endif

   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      prev_d  = level;
      evt_d   = level & ~prev_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         evt_q   <= evt_d;
      end
   end

   assign evt = evt_q;

endmodule

// File: rtl/digit_entry.sv
// Push-button entry of a three-digit signed BCD setpoint (ones, tens, hundreds) with idle timeout.
// Optional button debounce via DIGIT_ENTRY_DEBOUNCE_EN.
module digit_entry
   import digit_entry_pkg::*;
#(
   parameter int TIMEOUT_CYCLES  = 250000000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       btn_sign,
   output logic [1:0] input_state,
   output logic [3:0] current_input_value,
   output logic [3:0] temp_value_ones,
   output logic [3:0] temp_value_tens,
   output logic [3:0] temp_value_huns,
   output logic [4:0] temp_value_sign_bcd,
   output logic       temp_valid
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic ev_next, ev_inc, ev_dec, ev_sign, any_ev;

   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst(rst), .btn(btn_next), .evt(ev_next));
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .evt(ev_inc));
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec  (.clk(clk), .rst(rst), .btn(btn_dec),  .evt(ev_dec));
   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sign (.clk(clk), .rst(rst), .btn(btn_sign), .evt(ev_sign));

   input_state_e  state_q, state_d;
   logic [3:0]    cur_q, cur_d;
   logic [3:0]    ones_q, ones_d, tens_q, tens_d, huns_q, huns_d;
   logic [4:0]    sign_q, sign_d;
   logic          valid_q, valid_d;
   logic [3:0]    sh_ones_q, sh_ones_d, sh_tens_q, sh_tens_d, sh_huns_q, sh_huns_d;
   logic [4:0]    sh_sign_q, sh_sign_d;
   logic [TW-1:0] tmo_q, tmo_d;

   assign any_ev = ev_next | ev_inc | ev_dec | ev_sign;

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      ones_d    = ones_q;
      tens_d    = tens_q;
      huns_d    = huns_q;
      sign_d    = sign_q;
      valid_d   = 1'b0;
      sh_ones_d = sh_ones_q;
      sh_tens_d = sh_tens_q;
      sh_huns_d = sh_huns_q;
      sh_sign_d = sh_sign_q;

      if (state_q == INPUT_STATE_IDLE) begin
         // Shadow tracks the committed value so a timed-out entry can be undone.
         sh_ones_d = ones_q;
         sh_tens_d = tens_q;
         sh_huns_d = huns_q;
         sh_sign_d = sign_q;
         if (ev_next) begin
            state_d = INPUT_STATE_ONES;
            cur_d   = 4'd0;
         end
      end else if (any_ev) begin
         if (ev_sign) begin
            sign_d = (sign_q == BCD_MINUS) ? BCD_BLANK : BCD_MINUS;
         end
         if (ev_next) begin
            cur_d = 4'd0;
            case (state_q)
               INPUT_STATE_ONES: begin
                  ones_d  = cur_q;
                  state_d = INPUT_STATE_TENS;
               end
               INPUT_STATE_TENS: begin
                  tens_d  = cur_q;
                  state_d = INPUT_STATE_HUNS;
               end
               default: begin
                  huns_d  = cur_q;
                  state_d = INPUT_STATE_IDLE;
                  valid_d = 1'b1;
                  if (sign_d == BCD_MINUS && ones_q == 4'd0 && tens_q == 4'd0 && cur_q == 4'd0) begin
                     sign_d = BCD_BLANK;
                  end
               end
            endcase
         end else if (ev_inc && !ev_dec) begin
            cur_d = bcd_inc(cur_q);
         end else if (ev_dec && !ev_inc) begin
            cur_d = bcd_dec(cur_q);
         end
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = INPUT_STATE_IDLE;
         cur_d   = 4'd0;
         ones_d  = sh_ones_q;
         tens_d  = sh_tens_q;
         huns_d  = sh_huns_q;
         sign_d  = sh_sign_q;
      end

      tmo_d = (state_d == INPUT_STATE_IDLE || state_d != state_q || any_ev) ? '0 : tmo_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= INPUT_STATE_IDLE;
         cur_q     <= 4'd0;
         ones_q    <= 4'd0;
         tens_q    <= 4'd0;
         huns_q    <= 4'd0;
         sign_q    <= BCD_BLANK;
         valid_q   <= 1'b0;
         sh_ones_q <= 4'd0;
         sh_tens_q <= 4'd0;
         sh_huns_q <= 4'd0;
         sh_sign_q <= BCD_BLANK;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         ones_q    <= ones_d;
         tens_q    <= tens_d;
         huns_q    <= huns_d;
         sign_q    <= sign_d;
         valid_q   <= valid_d;
         sh_ones_q <= sh_ones_d;
         sh_tens_q <= sh_tens_d;
         sh_huns_q <= sh_huns_d;
         sh_sign_q <= sh_sign_d;
         tmo_q     <= tmo_d;
      end
   end

   assign input_state         = state_q;
   assign current_input_value = cur_q;
   assign temp_value_ones     = ones_q;
   assign temp_value_tens     = tens_q;
   assign temp_value_huns     = huns_q;
   assign temp_value_sign_bcd = sign_q;
   assign temp_valid          = valid_q;

endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: directed plan plus random button presses against a digit-level model.
module tb_digit_entry;
   import digit_entry_pkg::*;

   localparam int DB   = 8;
   localparam int HOLD = DB + 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_sign = 1'b0;
   logic [1:0] input_state;
   logic [3:0] current_input_value, temp_value_ones, temp_value_tens, temp_value_huns;
   logic [4:0] temp_value_sign_bcd;
   logic       temp_valid;

   digit_entry #(.TIMEOUT_CYCLES(64), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .rst(rst),
      .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_sign(btn_sign),
      .input_state(input_state), .current_input_value(current_input_value),
      .temp_value_ones(temp_value_ones), .temp_value_tens(temp_value_tens),
      .temp_value_huns(temp_value_huns), .temp_value_sign_bcd(temp_value_sign_bcd),
      .temp_valid(temp_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   logic valid_prev = 1'b0;
   logic [16:0] sb_q[$];

   // Reference model: digit positions 0=ones,1=tens,2=huns; state 0=idle, 1..3 = editing position state-1
   int m_state = 0, m_cur = 0;
   int m_d[3] = '{0, 0, 0};
   int sh_d[3] = '{0, 0, 0};
   bit m_neg = 0, sh_neg = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] sign_code(input bit neg);
      return neg ? BCD_MINUS : BCD_BLANK;
   endfunction

   task automatic model_press(input bit nx, input bit in, input bit de, input bit sg);
      if (m_state == 0) begin
         if (nx) begin
            sh_d = m_d;
            sh_neg = m_neg;
            m_state = 1;
            m_cur = 0;
         end
      end else begin
         if (sg) m_neg = !m_neg;
         if (nx) begin
            m_d[m_state-1] = m_cur;
            m_cur = 0;
            if (m_state == 3) begin
               m_state = 0;
               if (m_neg && m_d[0] + m_d[1] + m_d[2] == 0) m_neg = 0;
               sb_q.push_back({4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), sign_code(m_neg)});
            end else begin
               m_state++;
            end
         end else if (in != de) begin
            m_cur = in ? (m_cur + 1) % 10 : (m_cur + 9) % 10;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, " state"}, int'(input_state), m_state);
      chk({tag, " cur"}, int'(current_input_value), m_cur);
      chk({tag, " value"}, int'({temp_value_ones, temp_value_tens, temp_value_huns, temp_value_sign_bcd}),
          int'({4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), sign_code(m_neg)}));
   endtask

   task automatic press(input bit nx, input bit in, input bit de, input bit sg);
      model_press(nx, in, de, sg);
      @(posedge clk); #1;
      btn_next = nx; btn_inc = in; btn_dec = de; btn_sign = sg;
      repeat (HOLD) @(posedge clk);
      #1;
      btn_next = 0; btn_inc = 0; btn_dec = 0; btn_sign = 0;
      repeat (HOLD) @(posedge clk);
      #1;
      check_outputs("press");
   endtask

   task automatic press_n(input int n, input bit nx, input bit in, input bit de, input bit sg);
      for (int i = 0; i < n; i++) press(nx, in, de, sg);
   endtask

   // Monitor: every commit strobe must match the oldest expected value and last exactly one cycle
   always @(negedge clk) begin
      if (temp_valid) begin
         valid_cnt++;
         chk("valid_single_cycle", int'(valid_prev), 0);
         chk("valid_state_idle", int'(input_state), 0);
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            chk("commit_value", int'({temp_value_ones, temp_value_tens, temp_value_huns, temp_value_sign_bcd}),
                int'(sb_q.pop_front()));
         end
      end
      valid_prev = temp_valid;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_held", int'({input_state, current_input_value, temp_value_ones, temp_value_tens,
                              temp_value_huns, temp_value_sign_bcd, temp_valid}), int'({24'd0, BCD_BLANK, 1'b0}));
      rst = 0;
      repeat (100) @(posedge clk);
      #1;
      chk("no_valid_after_reset", valid_cnt, 0);
      check_outputs("post_reset");

      // 3,1,9
      press(1, 0, 0, 0); press_n(3, 0, 1, 0, 0); press(1, 0, 0, 0);
      press(0, 1, 0, 0); press(1, 0, 0, 0);
      press(0, 0, 1, 0); press(1, 0, 0, 0);
      chk("commit_319_seen", valid_cnt, 1);

      // Wrap both ways, then simultaneous inc/dec; enter 0,0,0 with a sign press
      press(1, 0, 0, 0); press(0, 0, 1, 0); press(0, 1, 0, 0); press(0, 1, 1, 0);
      press(0, 0, 0, 1); press_n(3, 1, 0, 0, 0);
      chk("neg_zero_blank", int'(temp_value_sign_bcd), int'(BCD_BLANK));

      // 5,0,0 negative
      press(1, 0, 0, 0); press_n(5, 0, 1, 0, 0); press(0, 0, 0, 1); press_n(3, 1, 0, 0, 0);
      chk("minus_five", int'({temp_value_sign_bcd, temp_value_ones}), int'({BCD_MINUS, 4'd5}));

      // 2,4,1 then abandoned entry after ones=7
      press(1, 0, 0, 0); press_n(2, 0, 1, 0, 0); press(1, 0, 0, 0);
      press_n(4, 0, 1, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0); press(1, 0, 0, 0);
      press(1, 0, 0, 0); press_n(7, 0, 1, 0, 0); press(0, 0, 0, 1); press(1, 0, 0, 0);
      begin
         int vc;
         vc = valid_cnt;
         repeat (100) @(posedge clk);
         #1;
         m_d = sh_d; m_neg = sh_neg; m_state = 0; m_cur = 0;
         check_outputs("timeout");
         chk("timeout_no_valid", valid_cnt, vc);
      end

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
      press(1, 0, 0, 0); press(0, 1, 0, 0);
      @(posedge clk); #1;
      btn_inc = 1;
      repeat (5) @(posedge clk);
      #1;
      btn_inc = 0;
      repeat (3 * HOLD) @(posedge clk);
      #1;
      check_outputs("glitch");
`endif

      // Random presses: mostly single buttons, occasionally inc+dec together
      for (int i = 0; i < 150; i++) begin
         int r;
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    press(1, 0, 0, 0);
            2, 3, 4: press(0, 1, 0, 0);
            5, 6:    press(0, 0, 1, 0);
            7:       press(0, 0, 0, 1);
            default: press(0, 1, 1, 0);
         endcase
      end

      // Asynchronous reset in the middle of TENS
      if (m_state != 0) press_n(4 - m_state, 1, 0, 0, 0);
      press(1, 0, 0, 0); press(0, 1, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
      chk("in_tens", int'(input_state), 2);
      @(posedge clk); #2;
      rst = 1;
      #1;
      chk("async_reset", int'({input_state, current_input_value, temp_value_ones, temp_value_tens,
                               temp_value_huns, temp_value_sign_bcd, temp_valid}), int'({24'd0, BCD_BLANK, 1'b0}));
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      m_state = 0; m_cur = 0; m_d = '{0, 0, 0}; m_neg = 0;
      repeat (5) @(posedge clk);
      #1;
      check_outputs("after_reset");
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- Operator-side writer for the 7-segment display path.
- Turns raw push-button activity into a three-digit signed BCD temperature setpoint, entered ones digit first, then tens, then hundreds.
- Drives input_state, current_input_value, temp_value_* and temp_value_sign_bcd, which the display mux consumes.
- Emits a one-cycle temp_valid strobe when a complete value is committed.

Parameters:
- TIMEOUT_CYCLES, 250000000: idle cycles in an entry state before the entry is aborted.
- DEBOUNCE_CYCLES, 500000: stable-sample count per button; used only with the optional debounce feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_next  in  1  raw button, asynchronous to clk; start entry / commit digit
- btn_inc  in  1  raw button; increment current digit
- btn_dec  in  1  raw button; decrement current digit
- btn_sign  in  1  raw button; toggle sign
- input_state  out  2  `INPUT_STATE_IDLE/ONES/TENS/HUNS
- current_input_value  out  4  digit under edit, 0..9
- temp_value_ones  out  4  committed ones digit
- temp_value_tens  out  4  committed tens digit
- temp_value_huns  out  4  committed hundreds digit
- temp_value_sign_bcd  out  5  `BCD_BLANK (positive) or `BCD_MINUS
- temp_valid  out  1  one-cycle strobe: new value committed

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: input_state=IDLE, current_input_value=0, all digits 0, sign=`BCD_BLANK, temp_valid=0. Shadow registers and timeout counter are cleared.
- Button conditioning: each button passes through a 2-flop synchronizer, then a rising-edge detector. Every press yields exactly one 1-cycle event, 3 cycles after the input settles. Holding a button yields no repeat events.
- IDLE:
  - next event -> ONES; current_input_value=0.
  - Digits and sign are copied into the shadow registers.
  - inc, dec and sign events are ignored.
- ONES, TENS and HUNS (entry states):
  - inc event: current = (current==9) ? 0 : current+1.
  - dec event: current = (current==0) ? 9 : current-1.
  - inc and dec in the same cycle: both are ignored.
  - sign event: toggles temp_value_sign_bcd between `BCD_BLANK and `BCD_MINUS, visible the next cycle.
  - next event: writes current into this state's digit (ones/tens/huns) and advances ONES->TENS->HUNS->IDLE. current is reloaded to 0 on each advance.
  - next has priority over inc and dec in the same cycle; the committed value is the pre-event current.
- Commit from HUNS:
  - input_state returns to IDLE and temp_valid=1 for exactly that first IDLE cycle.
  - If sign is `BCD_MINUS and all three digits are 0, sign is forced to `BCD_BLANK in the same cycle. The result is never -000.
- Timeout:
  - The counter clears on any button event or state change and increments in entry states.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE.
  - Digits and sign are restored from the shadow registers and current is set to 0.
  - temp_valid is not pulsed.
- Reset mid-entry: everything returns to the reset values. The shadow registers are not restored.
- current_input_value holds 0 in IDLE.
- The display mux owns pulsing of the digit under edit; this block drives no enables.

Optional Feature:
- Macro: DIGIT_ENTRY_DEBOUNCE_EN.
- Defined: each synchronized button feeds a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples disagreeing with the current level; edge detection runs on the debounced level. Event latency becomes 3+DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Undefined: sync plus edge detect only; DEBOUNCE_CYCLES is unused.

Decomposition:
- constants.h gains `INPUT_STATE_IDLE=2'd0, `INPUT_STATE_ONES=2'd1, `INPUT_STATE_TENS=2'd2, `INPUT_STATE_HUNS=2'd3.
- constants.h gains `BCD_MINUS beside the existing `BCD_BLANK. All display consumers share these constants.
- Sub-module btn_cond: synchronizer, optional debounce and rising-edge pulse, with a DEBOUNCE_CYCLES parameter. Instantiated four times.

Test Plan:
- Reset, then release: all outputs at reset values; temp_valid stays 0 for 100 cycles.
- Press next; press inc 3x, next; inc 1x, next; dec 1x, next -> digits ones=3, tens=1, huns=9. temp_valid high exactly 1 cycle; input_state=IDLE.
- In ONES: dec once from 0 -> current=9; inc once -> 0. Assert inc and dec on the same cycle -> current unchanged.
- Enter 0,0,0 with one sign press -> sign=`BCD_BLANK after commit. Enter 5,0,0 with sign -> `BCD_MINUS, ones=5.
- Commit 2,4,1; start a new entry, commit ones=7, then wait TIMEOUT_CYCLES (set to 64) -> IDLE with ones=2, tens=4, huns=1 restored and no temp_valid.
- Assert rst asynchronously mid-TENS -> outputs go to reset values without waiting for a clk edge. With DIGIT_ENTRY_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle btn_inc glitch produces no increment.
